adpll_tx_bit_serializer: RTL
============================

Name: adpll_tx_bit_serializer

Overview:
- TX symbol source directly upstream of adpll_ctr0. It drives adpll_ctr0's data_mod input.
- Accepts payload bytes over a valid/ready interface and buffers them in a small FIFO.
- Once adpll_ctr0 reports channel_lock in TX mode, it shifts the bytes out LSB-first as one bit per symbol period.
- Replaces the random data_mod stimulus with a deterministic, flow-controlled bit stream.

Parameters:
- SYM_DIV, 32, clk cycles per symbol (1 Mbps at 32 MHz clk); legal range 2..256.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  32 MHz reference clock, the same clock as adpll_ctr0.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; when 0, the FIFO is flushed.
- adpll_mode  in  2  PD=0, TEST=1, RX=2, TX=3.
- channel_lock  in  1  lock flag from adpll_ctr0.
- din  in  8  payload byte.
- din_valid  in  1  byte offered.
- din_ready  out  1  FIFO can accept a byte.
- whiten_seed  in  7  whitening LFSR seed; ignored unless the optional feature is compiled in.
- data_mod  out  1  modulation bit to adpll_ctr0, registered.
- busy  out  1  a byte is in flight or queued while in SEND.
- underrun  out  1  single-cycle pulse when the stream starves.

Behaviour:
- Reset (rst_n=0, async):
  - State IDLE; FIFO empty; sym_cnt=0; bits_left=0; tx_active=0.
  - Outputs: data_mod=0, din_ready=1, busy=0, underrun=0.
- FIFO:
  - Push when din_valid & din_ready & en.
  - din_ready = !full, evaluated on the current occupancy. A full FIFO never accepts a byte, even in a cycle where it also pops.
  - A push into an empty FIFO is not poppable in the same cycle.
  - en=0 flushes the FIFO and forces din_ready=1, but pushes are ignored.
- States:
  - IDLE: entered whenever en=0 or adpll_mode!=TX (from any state, next cycle). data_mod=0.
  - WAIT_LOCK: en=1, mode=TX, channel_lock=0. data_mod=0; sym_cnt held at 0.
  - SEND: entered from WAIT_LOCK on channel_lock=1, with sym_cnt=0 at entry.
- SEND timing:
  - sym_cnt counts 0..SYM_DIV-1 and wraps.
  - A symbol boundary is the cycle where sym_cnt==SYM_DIV-1. data_mod changes only at boundaries.
  - The first bit appears SYM_DIV cycles after SEND entry.
- At each boundary:
  - If bits_left>0: data_mod<=shreg[0]; shreg>>=1; bits_left-=1.
  - Else if FIFO not empty: data_mod<=head[0]; shreg<=head>>1; bits_left<=7; pop; tx_active<=1.
  - Else: data_mod<=0. If tx_active=1, underrun pulses for 1 cycle and tx_active<=0, giving exactly one pulse per starvation gap.
- Lock loss in SEND (channel_lock=0): next cycle go to WAIT_LOCK, data_mod=0, sym_cnt=0. The partially sent byte is discarded (bits_left=0). tx_active=0 with no underrun pulse.
- busy = (state==SEND) & (bits_left!=0 | FIFO not empty).
- Async reset mid-stream: immediate return to reset values; FIFO contents lost.

Optional Feature:
- Macro ADPLL_TX_WHITEN_EN.
- When defined:
  - 7-bit whitening LFSR s, loaded with whiten_seed on every WAIT_LOCK->SEND transition.
  - Each transmitted data bit is XORed with s[6], then s advances.
  - Advance rule: s <= {s[5:0], s[6]} with bit4 replaced by s[3]^s[6] (x^7+x^4+1).
  - Idle zero symbols are not whitened and do not advance s.
- When undefined: no LFSR logic; whiten_seed unused; data bits go out unmodified.

Test Plan:
- Reset check: rst_n=0 with din_valid=1 -> data_mod=0, din_ready=1, busy=0, underrun=0. After release, the state is IDLE.
- Lock gating: mode=3, en=1, lock=0, push 8'hA5 -> data_mod stays 0. Raise lock -> 32 cycles later data_mod sequence 1,0,1,0,0,1,0,1, each bit held exactly 32 cycles.
- Backpressure: lock=0, push 8'h01..8'h04 -> din_ready=0 after the 4th push, and the 5th byte is held. Raise lock -> din_ready returns to 1 one cycle after the first pop (cycle 32), and the 5th byte is accepted.
- Underrun: single byte 8'hFF sent -> at the 9th boundary data_mod=0 and underrun is high for exactly 1 cycle. No further pulse while the FIFO stays empty.
- Lock drop: drop lock after the 3rd bit of 8'h0F -> data_mod=0 next cycle. Relock with 8'h80 queued -> the output is 0,0,0,0,0,0,0,1, with no remnant of 8'h0F.
- Whitening (ADPLL_TX_WHITEN_EN): whiten_seed=7'b1000000, payload 8'h00 -> first four data_mod bits 1,0,0,1.

Source files
------------

// File: rtl/adpll_tx_bit_serializer.sv
// Byte FIFO plus LSB-first bit serializer that drives adpll_ctr0 data_mod once the loop is locked in TX.
// Optional x^7+x^4+1 data whitening is compiled in with `define ADPLL_TX_WHITEN_EN.
module adpll_tx_bit_serializer #(
  parameter int SYM_DIV    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] adpll_mode,
  input  logic       channel_lock,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [6:0] whiten_seed,
  output logic       data_mod,
  output logic       busy,
  output logic       underrun
);
  localparam int CW = $clog2(SYM_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0]    MODE_TX  = 2'd3;
  localparam logic [CW-1:0] SYM_LAST = CW'(SYM_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, SEND} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] sym_cnt_q, sym_cnt_d;
  logic [2:0]    bits_left_q, bits_left_d;
  logic [6:0]    shreg_q, shreg_d;
  logic          data_mod_q, data_mod_d;
  logic          tx_active_q, tx_active_d;
  logic          underrun_q, underrun_d;
  logic          fifo_empty, fifo_full, push, pop, boundary;
  logic          shift_out, tx_bit, white_bit;
  logic [7:0]    head;

`ifdef ADPLL_TX_WHITEN_EN
  logic [6:0] lfsr_q, lfsr_d;
  assign white_bit = lfsr_q[6];
`else
  logic unused_seed;
  assign unused_seed = ^whiten_seed;
  assign white_bit   = 1'b0;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  // Readiness looks only at current occupancy, so a full FIFO refuses even while popping.
  assign din_ready  = !fifo_full || !en;
  assign push       = en && din_valid && !fifo_full;
  assign head       = mem[rd_ptr_q];
  assign boundary   = (sym_cnt_q == SYM_LAST);

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    bits_left_d = bits_left_q;
    shreg_d     = shreg_q;
    data_mod_d  = data_mod_q;
    tx_active_d = tx_active_q;
    underrun_d  = 1'b0;
    pop         = 1'b0;
    shift_out   = 1'b0;
    tx_bit      = 1'b0;
`ifdef ADPLL_TX_WHITEN_EN
    lfsr_d      = lfsr_q;
`endif
    if (!en || adpll_mode != MODE_TX) begin
      state_d     = IDLE;
      sym_cnt_d   = '0;
      bits_left_d = '0;
      data_mod_d  = 1'b0;
      tx_active_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = WAIT_LOCK;
          sym_cnt_d  = '0;
          data_mod_d = 1'b0;
        end
        WAIT_LOCK: begin
          sym_cnt_d  = '0;
          data_mod_d = 1'b0;
          if (channel_lock) begin
            state_d = SEND;
`ifdef ADPLL_TX_WHITEN_EN
            lfsr_d  = whiten_seed;
`endif
          end
        end
        SEND: begin
          if (!channel_lock) begin
            // Losing lock drops the partial byte silently; no underrun is reported.
            state_d     = WAIT_LOCK;
            sym_cnt_d   = '0;
            bits_left_d = '0;
            tx_active_d = 1'b0;
            data_mod_d  = 1'b0;
          end else begin
            sym_cnt_d = boundary ? '0 : sym_cnt_q + CW'(1);
            if (boundary) begin
              if (bits_left_q != '0) begin
                shift_out   = 1'b1;
                tx_bit      = shreg_q[0];
                shreg_d     = shreg_q >> 1;
                bits_left_d = bits_left_q - 3'd1;
              end else if (!fifo_empty) begin
                shift_out   = 1'b1;
                tx_bit      = head[0];
                shreg_d     = head[7:1];
                bits_left_d = 3'd7;
                pop         = 1'b1;
                tx_active_d = 1'b1;
              end else begin
                data_mod_d = 1'b0;
                if (tx_active_q) begin
                  underrun_d  = 1'b1;
                  tx_active_d = 1'b0;
                end
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (shift_out) begin
      data_mod_d = tx_bit ^ white_bit;
`ifdef ADPLL_TX_WHITEN_EN
      lfsr_d     = {lfsr_q[5:0], lfsr_q[6]} ^ {2'b00, lfsr_q[6], 4'b0000};
`endif
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sym_cnt_q   <= '0;
      bits_left_q <= '0;
      shreg_q     <= '0;
      data_mod_q  <= 1'b0;
      tx_active_q <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef ADPLL_TX_WHITEN_EN
      lfsr_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sym_cnt_q   <= sym_cnt_d;
      bits_left_q <= bits_left_d;
      shreg_q     <= shreg_d;
      data_mod_q  <= data_mod_d;
      tx_active_q <= tx_active_d;
      underrun_q  <= underrun_d;
`ifdef ADPLL_TX_WHITEN_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign data_mod = data_mod_q;
  assign underrun = underrun_q;
  assign busy     = (state_q == SEND) && ((bits_left_q != '0) || !fifo_empty);

endmodule
